// File: rtl/bldc_hall_emulator.sv
// rtl/bldc_hall_emulator.sv - BLDC rotor emulator producing hall signals from observed gate drives
module bldc_hall_emulator #(
  parameter int STEP_CYC = 5000,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             aa,
  input  logic             bb,
  input  logic             cc,
  output logic             h1,
  output logic             h2,
  output logic             h3,
  output logic [2:0]       sector,
  output logic [CNT_W-1:0] step_cnt,
  output logic             stall,
  output logic             fault
);

  localparam int DW = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam logic [DW-1:0] LAST = DW'(STEP_CYC - 1);

  logic [DW-1:0] dwell;
  logic [2:0]    hi_seen, lo_seen, hi_next, lo_next;
  logic [2:0]    hall, sector_step;
  logic          shoot, window_ok;

  function automatic logic one_hot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  // Out-of-range sectors decode as sector 0
  function automatic logic [2:0] decode(input logic [2:0] s);
    case (s)
      3'd1:    return 3'b101;
      3'd2:    return 3'b001;
      3'd3:    return 3'b011;
      3'd4:    return 3'b010;
      3'd5:    return 3'b110;
      default: return 3'b100;
    endcase
  endfunction

  always_comb begin
    hi_next   = hi_seen | {a, b, c};
    lo_next   = lo_seen | {aa, bb, cc};
    shoot     = (a & aa) | (b & bb) | (c & cc);
    window_ok = one_hot3(hi_next) && one_hot3(lo_next) && ((hi_next & lo_next) == 3'b000);
    if (sector > 3'd5)
      sector_step = 3'd0;
    else if (!dir)
      sector_step = (sector == 3'd5) ? 3'd0 : sector + 3'd1;
    else
      sector_step = (sector == 3'd0) ? 3'd5 : sector - 3'd1;
  end

  // Hall outputs are registered alongside the sector so they switch cleanly in one edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell    <= '0;
      hi_seen  <= '0;
      lo_seen  <= '0;
      sector   <= 3'd0;
      hall     <= 3'b100;
      step_cnt <= '0;
      stall    <= 1'b0;
      fault    <= 1'b0;
    end else begin
      if (shoot)
        fault <= 1'b1;
      if (!fault) begin
        if (!en) begin
          dwell   <= '0;
          hi_seen <= '0;
          lo_seen <= '0;
        end else if (dwell == LAST) begin
          dwell   <= '0;
          hi_seen <= '0;
          lo_seen <= '0;
          if (!shoot) begin
            if (window_ok) begin
              sector   <= sector_step;
              hall     <= decode(sector_step);
              step_cnt <= step_cnt + 1'b1;
              stall    <= 1'b0;
            end else begin
              stall <= 1'b1;
            end
          end
        end else begin
          dwell   <= dwell + 1'b1;
          hi_seen <= hi_next;
          lo_seen <= lo_next;
        end
      end
    end
  end

  assign {h1, h2, h3} = hall;

endmodule
